// File: rtl/alu_pkg.sv
// Shared encodings for the ALU front-end: one-hot sequencer states,
// ALU opcodes and bit positions of the latched flag vector.
package alu_pkg;

  localparam logic [4:0] S_GET_A  = 5'b00001;
  localparam logic [4:0] S_GET_B  = 5'b00010;
  localparam logic [4:0] S_GET_OP = 5'b00100;
  localparam logic [4:0] S_EXEC   = 5'b01000;
  localparam logic [4:0] S_SHOW   = 5'b10000;

  typedef enum logic [4:0] {
    ST_GET_A  = S_GET_A,
    ST_GET_B  = S_GET_B,
    ST_GET_OP = S_GET_OP,
    ST_EXEC   = S_EXEC,
    ST_SHOW   = S_SHOW
  } state_e;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 2;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and a
// registered one-cycle pulse on each accepted rising level.
// Ports: clk, rst_n (sync, active-low), btn_raw in, press out.
module btn_debounce
  import alu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Pulse comes from the already-registered level, so it lags the
    // level flip by one edge.
    press_d = level_q & ~level_dly_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
      press_q     <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Captures A, B and OP from the switch bank on enter presses, runs one
// EXEC cycle on the ALU and latches its result and flags for display.
// Ports: sw/buttons in, alu_* in; a/b/op to ALU; stage, res_q, flags_q,
// res_valid to the display.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16'd50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       btn_enter,
  input  logic       btn_clear,
  input  logic [3:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [2:0] op,
  output logic [4:0] stage,
  output logic [3:0] res_q,
  output logic [2:0] flags_q,
  output logic       res_valid
);

  logic enter_p, clear_p;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_enter (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_enter),
    .press  (enter_p)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_clear (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_clear),
    .press  (clear_p)
  );

  state_e     state_q, state_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic [2:0] op_q, op_d;
  logic [3:0] res_d;
  logic [3:0] res_r;
  logic [2:0] flags_r, flags_d;
  logic       valid_q, valid_d;
  logic       clr_pend_q, clr_pend_d;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    res_d      = res_r;
    flags_d    = flags_r;
    valid_d    = valid_q;
    clr_pend_d = 1'b0;
    if (state_q == ST_EXEC) begin
      // Result always lands; a clear seen here is replayed in SHOW.
      res_d              = alu_result;
      flags_d[FLAG_C]    = alu_carry;
      flags_d[FLAG_V]    = alu_overflow;
      flags_d[FLAG_Z]    = alu_zero;
      valid_d            = 1'b1;
      clr_pend_d         = clear_p;
      state_d            = ST_SHOW;
    end else if (clear_p || clr_pend_q) begin
      state_d = ST_GET_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      res_d   = '0;
      flags_d = '0;
      valid_d = 1'b0;
    end else if (enter_p) begin
      unique case (1'b1)
        state_q[0]: begin
          a_d     = sw;
          state_d = ST_GET_B;
        end
        state_q[1]: begin
          b_d     = sw;
          state_d = ST_GET_OP;
        end
        state_q[2]: begin
          op_d    = sw[2:0];
          state_d = ST_EXEC;
        end
        state_q[4]: begin
          valid_d = 1'b0;
          state_d = ST_GET_A;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_GET_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      res_r      <= '0;
      flags_r    <= '0;
      valid_q    <= 1'b0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      res_r      <= res_d;
      flags_r    <= flags_d;
      valid_q    <= valid_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign op        = op_q;
  assign stage     = state_q;
  assign res_q     = res_r;
  assign flags_q   = flags_r;
  assign res_valid = valid_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer with a behavioural 4-bit ALU attached.
// Table vectors, random operations and hand-built corner sequences.
module tb_alu_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       btn_enter, btn_clear;
  logic [3:0] alu_result;
  logic       alu_carry, alu_zero, alu_overflow;
  logic [3:0] a, b;
  logic [2:0] op;
  logic [4:0] stage;
  logic [3:0] res_q;
  logic [2:0] flags_q;
  logic       res_valid;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] GA = 5'b00001;
  localparam logic [4:0] GB = 5'b00010;
  localparam logic [4:0] GO = 5'b00100;
  localparam logic [4:0] EX = 5'b01000;
  localparam logic [4:0] SH = 5'b10000;

  always #5 clk = ~clk;

  alu_operand_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw          (sw),
    .btn_enter   (btn_enter),
    .btn_clear   (btn_clear),
    .alu_result  (alu_result),
    .alu_carry   (alu_carry),
    .alu_zero    (alu_zero),
    .alu_overflow(alu_overflow),
    .a           (a),
    .b           (b),
    .op          (op),
    .stage       (stage),
    .res_q       (res_q),
    .flags_q     (flags_q),
    .res_valid   (res_valid)
  );

  // Returns {result[3:0], carry, overflow, zero}.
  function automatic logic [6:0] ref_alu(
    input logic [3:0] x, input logic [3:0] y, input logic [2:0] o);
    int sx, sy, r, s;
    logic [3:0] res;
    logic c, v;
    sx = (x > 7) ? int'(x) - 16 : int'(x);
    sy = (y > 7) ? int'(y) - 16 : int'(y);
    c = 1'b0;
    v = 1'b0;
    r = 0;
    case (o)
      3'd0: begin
        r = int'(x) + int'(y);
        s = sx + sy;
        c = (r > 15);
        v = (s > 7) || (s < -8);
      end
      3'd1: begin
        r = int'(x) - int'(y);
        s = sx - sy;
        c = (x < y);
        v = (s > 7) || (s < -8);
      end
      3'd2: r = 15 - int'(x);
      3'd3: r = int'(x & y);
      3'd4: r = int'(x | y);
      3'd5: r = int'(x ^ y);
      3'd6: r = (sx < sy) ? 1 : 0;
      default: r = (x == y) ? 1 : 0;
    endcase
    res = r[3:0];
    return {res, c, v, res == 4'd0};
  endfunction

  always_comb begin
    {alu_result, alu_carry, alu_overflow, alu_zero} = ref_alu(a, b, op);
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_enter(input logic [3:0] val);
    sw = val;
    btn_enter = 1'b1;
    tick(10);
    btn_enter = 1'b0;
    tick(10);
  endtask

  task automatic press_clear();
    btn_clear = 1'b1;
    tick(10);
    btn_clear = 1'b0;
    tick(10);
  endtask

  task automatic run_op(input string tag,
                        input logic [3:0] x, input logic [3:0] y,
                        input logic [2:0] o,
                        input logic [3:0] er, input logic [2:0] ef);
    press_enter(x);
    press_enter(y);
    press_enter({1'b0, o});
    check({tag, "_a"}, a, x);
    check({tag, "_b"}, b, y);
    check({tag, "_op"}, op, o);
    check({tag, "_stage"}, stage, SH);
    check({tag, "_res"}, res_q, er);
    check({tag, "_flags"}, flags_q, ef);
    check({tag, "_valid"}, res_valid, 1);
    press_enter(4'h0);
    check({tag, "_back"}, stage, GA);
    check({tag, "_vclr"}, res_valid, 0);
    check({tag, "_keep"}, a, x);
  endtask

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] o;
    logic [3:0] er;
    logic [2:0] ef;
  } vec_t;

  vec_t tbl[8];
  logic [6:0] m;
  logic [3:0] rx, ry;
  logic [2:0] ro;
  int n;
  logic bounce [20];

  initial begin
    tbl[0] = '{4'd3, 4'd5, 3'b001, 4'b1110, 3'b100};
    tbl[1] = '{4'd7, 4'd1, 3'b000, 4'b1000, 3'b010};
    tbl[2] = '{4'd8, 4'd8, 3'b000, 4'b0000, 3'b111};
    tbl[3] = '{4'hC, 4'hA, 3'b011, 4'h8, 3'b000};
    tbl[4] = '{4'hF, 4'h1, 3'b110, 4'h1, 3'b000};
    tbl[5] = '{4'h5, 4'h5, 3'b111, 4'h1, 3'b000};
    tbl[6] = '{4'h0, 4'h3, 3'b010, 4'hF, 3'b000};
    tbl[7] = '{4'h5, 4'h5, 3'b101, 4'h0, 3'b001};
    bounce = '{1, 0, 1, 1, 0, 1, 0, 0, 1, 1,
               0, 1, 1, 0, 0, 1, 0, 1, 0, 0};

    rst_n = 1'b0;
    sw = 4'h0;
    btn_enter = 1'b0;
    btn_clear = 1'b0;

    // Reset with buttons toggling
    for (int i = 0; i < 3; i++) begin
      btn_enter = ~btn_enter;
      btn_clear = i[0];
      tick();
    end
    check("rst_stage", stage, GA);
    check("rst_a", {a, b, op}, 0);
    check("rst_res", {res_q, flags_q, res_valid}, 0);
    rst_n = 1'b1;
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    tick(12);
    check("rst_nopulse", stage, GA);

    // Bouncy enter, then a clean hold
    sw = 4'hA;
    foreach (bounce[i]) begin
      btn_enter = bounce[i];
      tick();
    end
    check("bounce_ignored", stage, GA);
    btn_enter = 1'b1;
    n = 0;
    while (stage == GA && n < 12) begin
      tick();
      n++;
    end
    check("db_latency_ok", (n >= 7 && n <= 8), 1);
    check("db_adv", stage, GB);
    check("db_a", a, 4'hA);
    tick(10 - n);
    btn_enter = 1'b0;
    tick(12);
    check("db_release", stage, GB);
    press_clear();
    check("db_clr", stage, GA);

    // Hand sequence: exactly one cycle in EXEC
    press_enter(4'd3);
    press_enter(4'd5);
    sw = 4'b0001;
    btn_enter = 1'b1;
    tick(8);
    check("exec_stage", stage, EX);
    check("exec_ops", {a, b, op}, {4'd3, 4'd5, 3'b001});
    tick();
    check("exec_show", stage, SH);
    check("exec_res", res_q, 4'b1110);
    btn_enter = 1'b0;
    tick(12);
    press_enter(4'h0);

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y, tbl[i].o,
             tbl[i].er, tbl[i].ef);
    end

    // Random operations against the reference ALU
    for (int i = 0; i < 12; i++) begin
      rx = 4'($urandom_range(0, 15));
      ry = 4'($urandom_range(0, 15));
      ro = 3'($urandom_range(0, 7));
      m = ref_alu(rx, ry, ro);
      run_op($sformatf("rnd%0d", i), rx, ry, ro, m[6:3], m[2:0]);
    end

    // Clear in GET_OP
    press_enter(4'd2);
    press_enter(4'd6);
    check("pre_clr", stage, GO);
    press_clear();
    check("clr_stage", stage, GA);
    check("clr_ops", {a, b, op}, 0);

    // Clear and enter together: clear wins
    press_enter(4'd9);
    check("both_pre", a, 4'd9);
    sw = 4'd4;
    btn_enter = 1'b1;
    btn_clear = 1'b1;
    tick(10);
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    tick(10);
    check("both_stage", stage, GA);
    check("both_a", a, 0);

    // Clear pulse landing in EXEC
    press_enter(4'd4);
    press_enter(4'd3);
    sw = 4'd0;
    btn_enter = 1'b1;
    tick();
    btn_clear = 1'b1;
    tick(7);
    check("xclr_exec", stage, EX);
    tick();
    check("xclr_show", stage, SH);
    check("xclr_res", res_q, 4'd7);
    check("xclr_valid", res_valid, 1);
    tick();
    check("xclr_stage", stage, GA);
    check("xclr_vclr", res_valid, 0);
    check("xclr_all", {a, b, op, res_q, flags_q}, 0);
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    tick(12);

    // Reset during EXEC discards the operation
    press_enter(4'd1);
    press_enter(4'd1);
    sw = 4'd0;
    btn_enter = 1'b1;
    tick(8);
    check("rexec_pre", stage, EX);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    btn_enter = 1'b0;
    check("rexec_stage", stage, GA);
    check("rexec_res", {res_q, res_valid}, 0);
    tick(12);
    check("rexec_idle", stage, GA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
